// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Purpose  : Round-robin, burst-granting arbiter that shares the FIFO memory
//            write port between NREQ valid/ready requesters. Drives the
//            memory write strobe/address/data and owns the binary write
//            pointer. Stalls (without losing the grant) while wfull is high.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic [DATASIZE-1:0]      wdata,
  output logic [ADDRSIZE-1:0]      waddr,
  output logic                     wclken,
  output logic [ADDRSIZE:0]        wptr,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy
);

  localparam int GW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST + 1);

  localparam logic [0:0]    S_IDLE      = 1'b0;
  localparam logic [0:0]    S_BURST     = 1'b1;
  localparam logic [BW-1:0] C_LAST_BEAT = BW'(MAXBURST - 1);
  localparam logic [GW-1:0] C_GNT_INIT  = GW'(NREQ - 1);
  localparam logic [GW:0]   C_NREQ      = (GW+1)'(NREQ);

  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [BW-1:0] beats;
  logic          any_valid;
  logic [GW-1:0] pick;
  logic          found;
  logic [GW:0]   search_sum;
  logic          gnt_valid;
  logic          gnt_last;

  assign any_valid = |req_valid;
  assign waddr     = wptr[ADDRSIZE-1:0];

  // Round-robin search: first valid requester starting just after gnt_id.
  always_comb begin
    found      = 1'b0;
    pick       = gnt_id;
    search_sum = '0;
    for (int k = 1; k <= NREQ; k++) begin
      search_sum = {1'b0, gnt_id} + (GW+1)'(k);
      if (search_sum >= C_NREQ) begin
        search_sum = search_sum - C_NREQ;
      end
      if (!found && req_valid[search_sum[GW-1:0]]) begin
        found = 1'b1;
        pick  = search_sum[GW-1:0];
      end
    end
  end

  // Granted-requester muxes; the loop guarantees wdata is always driven.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    wdata     = req_data[DATASIZE-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == GW'(i)) begin
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
        wdata     = req_data[i*DATASIZE +: DATASIZE];
      end
    end
  end

  // State register.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: burst ends on last word, beat limit, or requester give-up.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (any_valid) begin
          state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (!gnt_valid) begin
          state_nxt = S_IDLE;
        end else if (wclken && (gnt_last || (beats == C_LAST_BEAT))) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: only the granted requester sees ready; reset cycle issues nothing.
  always_comb begin
    req_ready = '0;
    wclken    = 1'b0;
    busy      = (state == S_BURST);
    if ((state == S_BURST) && !wrst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_id == GW'(i)) begin
          req_ready[i] = !wfull;
        end
      end
      wclken = gnt_valid & !wfull;
    end
  end

  // Datapath: grant capture, beat counter and write pointer.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr   <= '0;
      beats  <= '0;
      gnt_id <= C_GNT_INIT;
    end else begin
      if (state == S_IDLE) begin
        beats <= '0;
        if (any_valid) begin
          gnt_id <= pick;
        end
      end
      if (wclken) begin
        wptr  <= wptr + (ADDRSIZE+1)'(1);
        beats <= beats + BW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Purpose  : Directed self-checking bench for fifo_write_arbiter with the
//            default parameters (8-bit data, 4-bit address, 4 requesters,
//            bursts of at most 4 words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic [7:0]  wdata;
  logic [3:0]  waddr;
  logic        wclken;
  logic [4:0]  wptr;
  logic [1:0]  gnt_id;
  logic        busy;

  int          n_vec;
  int          n_bad;
  logic [4:0]  exp_ptr;

  fifo_write_arbiter #(
    .DATASIZE(8), .ADDRSIZE(4), .NREQ(4), .MAXBURST(4)
  ) dut (
    .wclk     (clk),
    .wrst     (rst),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_data (req_data),
    .req_ready(req_ready),
    .wfull    (wfull),
    .wdata    (wdata),
    .waddr    (waddr),
    .wclken   (wclken),
    .wptr     (wptr),
    .gnt_id   (gnt_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-requester data pattern for beat b: byte i = (i+1)*0x10 + b.
  function automatic logic [31:0] pat(input int b);
    logic [7:0] x;
    x = b[7:0];
    return {8'h40 + x, 8'h30 + x, 8'h20 + x, 8'h10 + x};
  endfunction

  // One clock cycle: apply inputs, check mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] l,
                     input logic f, input logic r, input logic [31:0] d,
                     input logic ew, input logic [3:0] erdy,
                     input logic [1:0] egnt, input logic ebusy);
    req_valid = v;
    req_last  = l;
    wfull     = f;
    rst       = r;
    req_data  = d;
    #4;
    chk({tag, ".wclken"}, 32'(wclken), 32'(ew));
    chk({tag, ".ready"}, 32'(req_ready), 32'(erdy));
    chk({tag, ".wptr"}, 32'(wptr), 32'(exp_ptr));
    chk({tag, ".waddr"}, 32'(waddr), 32'(exp_ptr[3:0]));
    chk({tag, ".gnt"}, 32'(gnt_id), 32'(egnt));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    if (ew) begin
      chk({tag, ".wdata"}, 32'(wdata), 32'(d[egnt*8 +: 8]));
      exp_ptr = exp_ptr + 5'd1;
    end
    @(posedge clk);
    #1;
    if (r) exp_ptr = '0;
  endtask

  // Arbitration cycle followed by n accepted beats from requester g.
  task automatic burst(input string tag, input logic [3:0] v, input int g,
                       input int n, input int prev, input bit end_last);
    logic [3:0] rdy;
    rdy = 4'b0001 << g;
    cyc({tag, ".arb"}, v, 4'b0000, 1'b0, 1'b0, pat(0), 1'b0, 4'b0000, 2'(prev), 1'b0);
    for (int b = 0; b < n; b++) begin
      cyc({tag, ".beat"}, v, (end_last && b == n-1) ? v : 4'b0000, 1'b0, 1'b0,
          pat(b), 1'b1, rdy, 2'(g), 1'b1);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    exp_ptr   = '0;
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    cyc("rst", 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 1'b0, 4'b0000, 2'd3, 1'b0);

    // 1: req0, three words, last on the third.
    burst("t1", 4'b0001, 0, 3, 3, 1'b1);
    cyc("t1.idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 2'd0, 1'b0);

    // 2: fresh reset, all four requesters streaming, bursts capped at 4.
    cyc("t2.rst", 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h0, 1'b0, 4'b0000, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      burst("t2", 4'b1111, k % 4, 4, (k == 0) ? 3 : (k - 1) % 4, 1'b0);
    end
    chk("t2.round_ptr", 32'(wptr), 32'd20);

    // 3: req1 stalls on wfull for 5 cycles mid-burst, then resumes.
    burst("t3", 4'b0010, 1, 1, 0, 1'b0);
    for (int s = 0; s < 5; s++) begin
      cyc("t3.stall", 4'b0010, 4'b0000, 1'b1, 1'b0, pat(1), 1'b0, 4'b0000, 2'd1, 1'b1);
    end
    cyc("t3.resume", 4'b0010, 4'b0010, 1'b0, 1'b0, pat(1), 1'b1, 4'b0010, 2'd1, 1'b1);

    // Bring the pointer to 30, then 4: wrap across 31 -> 0.
    burst("t4pre", 4'b0100, 2, 4, 1, 1'b0);
    burst("t4pre", 4'b0100, 2, 4, 2, 1'b0);
    chk("t4.start_ptr", 32'(wptr), 32'd30);
    burst("t4", 4'b1000, 3, 4, 2, 1'b0);
    chk("t4.end_ptr", 32'(wptr), 32'd2);

    // 5: reset during the second beat of req1's burst; req0 wins next.
    burst("t5", 4'b0010, 1, 1, 3, 1'b0);
    cyc("t5.rst", 4'b0011, 4'b0000, 1'b0, 1'b1, pat(1), 1'b0, 4'b0000, 2'd1, 1'b1);
    burst("t5.after", 4'b0011, 0, 1, 3, 1'b1);

    // 6: req2 gives up after one word; req3 next, then wrap to req0.
    burst("t6", 4'b0100, 2, 1, 0, 1'b0);
    cyc("t6.drop", 4'b0000, 4'b0000, 1'b0, 1'b0, pat(1), 1'b0, 4'b0100, 2'd2, 1'b1);
    burst("t6.next", 4'b1001, 3, 1, 2, 1'b1);
    burst("t6.wrap", 4'b0001, 0, 1, 3, 1'b1);
    cyc("t6.idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
